// File: rtl/mem_access_unit.sv
// MIPS memory stage: consumes EX/MEM, runs the data-memory handshake, produces registered MEM/WB results.
// Optional `MEM_ALIGN_CHECK_EN: misaligned half/word accesses retire as no-ops with a misalign pulse.
module mem_access_unit #(
   parameter int MEM_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [MEM_WIDTH-1:0] alu_in,
   input  logic [MEM_WIDTH-1:0] valB_in,
   input  logic [4:0]           dest_in,
   input  logic [5:0]           op_in,
   input  logic [7:0]           signals_in,
   output logic                 hold,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [MEM_WIDTH-1:0] mem_addr,
   output logic [MEM_WIDTH-1:0] mem_wdata,
   output logic [3:0]           mem_be,
   input  logic                 mem_ready,
   input  logic [MEM_WIDTH-1:0] mem_rdata,
   output logic [MEM_WIDTH-1:0] wb_data,
   output logic [4:0]           wb_dest,
   output logic                 wb_regwrite,
   output logic                 wb_valid,
   output logic                 misalign
);

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_next_s;
   logic            is_mem_s;
   logic            misalign_s;
   logic            access_s;
   logic            retire_s;
   logic [31:0]     load_data_r;
   logic [31:0]     wb_data_s;
   logic            wb_regwrite_s;
   logic            unused_s;

   function automatic logic is_load(input logic [5:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
         default:                            is_load = 1'b0;
      endcase
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      case (op)
         OP_SB, OP_SH, OP_SW: is_store = 1'b1;
         default:             is_store = 1'b0;
      endcase
   endfunction

   // Non-memory opcodes report word size; callers qualify with is_mem_s.
   function automatic logic [1:0] size_of(input logic [5:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: size_of = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: size_of = SZ_HALF;
         default:              size_of = SZ_WORD;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [5:0] op, input logic [1:0] a);
      case (size_of(op))
         SZ_BYTE: byte_en = 4'b0001 << a;
         SZ_HALF: byte_en = a[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_data(input logic [5:0] op, input logic [31:0] v);
      case (size_of(op))
         SZ_BYTE: store_data = {4{v[7:0]}};
         SZ_HALF: store_data = {2{v[15:0]}};
         default: store_data = v;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [5:0] op, input logic [1:0] a,
                                            input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(d >> {a, 3'b000});
      h = a[1] ? d[31:16] : d[15:0];
      case (op)
         OP_LB:   load_ext = {{24{b[7]}}, b};
         OP_LBU:  load_ext = {24'h000000, b};
         OP_LH:   load_ext = {{16{h[15]}}, h};
         OP_LHU:  load_ext = {16'h0000, h};
         default: load_ext = d;
      endcase
   endfunction

   assign is_mem_s = is_load(op_in) | is_store(op_in);
   assign access_s = is_mem_s & ~misalign_s;
   assign unused_s = ^{signals_in[7:3], signals_in[1:0]};

`ifdef MEM_ALIGN_CHECK_EN
   // Alignment check on the instruction sitting in EX/MEM.
   always_comb begin
      misalign_s = 1'b0;
      if (is_mem_s) begin
         case (size_of(op_in))
            SZ_HALF: misalign_s = alu_in[0];
            SZ_WORD: misalign_s = (alu_in[1:0] != 2'b00);
            default: misalign_s = 1'b0;
         endcase
      end else begin
         misalign_s = 1'b0;
      end
   end
`else
   assign misalign_s = 1'b0;
`endif

   // Next-state, hold and retire decode; hold never looks at mem_ready.
   always_comb begin
      state_next_s = state_r;
      hold         = 1'b0;
      retire_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (access_s) begin
               hold         = 1'b1;
               state_next_s = REQ;
            end else begin
               retire_s     = 1'b1;
            end
         end
         REQ: begin
            hold = 1'b1;
            if (mem_ready) begin
               state_next_s = DONE;
            end else begin
               state_next_s = REQ;
            end
         end
         DONE: begin
            retire_s     = 1'b1;
            state_next_s = IDLE;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Writeback value selection for the retiring instruction.
   always_comb begin
      wb_data_s     = 32'h0000_0000;
      wb_regwrite_s = 1'b0;
      if (state_r == DONE) begin
         if (is_store(op_in)) begin
            wb_data_s     = 32'h0000_0000;
            wb_regwrite_s = 1'b0;
         end else begin
            wb_data_s     = load_data_r;
            wb_regwrite_s = signals_in[2];
         end
      end else if (misalign_s) begin
         wb_data_s     = 32'h0000_0000;
         wb_regwrite_s = 1'b0;
      end else begin
         wb_data_s     = alu_in;
         wb_regwrite_s = signals_in[2];
      end
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Memory request registers: launched leaving IDLE, frozen through REQ, data captured on ready.
   always_ff @(posedge clock) begin
      if (reset) begin
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'h0000_0000;
         mem_wdata   <= 32'h0000_0000;
         mem_be      <= 4'b0000;
         load_data_r <= 32'h0000_0000;
      end else if ((state_r == IDLE) && access_s) begin
         mem_req   <= 1'b1;
         mem_we    <= is_store(op_in);
         mem_addr  <= {alu_in[31:2], 2'b00};
         mem_be    <= byte_en(op_in, alu_in[1:0]);
         mem_wdata <= is_store(op_in) ? store_data(op_in, valB_in) : 32'h0000_0000;
      end else if ((state_r == REQ) && mem_ready) begin
         mem_req     <= 1'b0;
         load_data_r <= load_ext(op_in, alu_in[1:0], mem_rdata);
      end
   end

   // MEM/WB output registers; regwrite is qualified so idle cycles never write.
   always_ff @(posedge clock) begin
      if (reset) begin
         wb_data     <= 32'h0000_0000;
         wb_dest     <= 5'd0;
         wb_regwrite <= 1'b0;
         wb_valid    <= 1'b0;
         misalign    <= 1'b0;
      end else begin
         wb_valid    <= retire_s;
         wb_regwrite <= retire_s & wb_regwrite_s;
         misalign    <= retire_s & misalign_s & (state_r == IDLE);
         if (retire_s) begin
            wb_data <= wb_data_s;
            wb_dest <= dest_in;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan steps plus randomized ops against a byte-level model.
module tb_mem_access_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] alu_in;
   logic [31:0] valB_in;
   logic [4:0]  dest_in;
   logic [5:0]  op_in;
   logic [7:0]  signals_in;
   logic        hold;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] wb_data;
   logic [4:0]  wb_dest;
   logic        wb_regwrite;
   logic        wb_valid;
   logic        misalign;

   int tests  = 0;
   int failed = 0;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   mem_access_unit #(.MEM_WIDTH(32)) dut (
      .clock(clock), .reset(reset), .alu_in(alu_in), .valB_in(valB_in),
      .dest_in(dest_in), .op_in(op_in), .signals_in(signals_in), .hold(hold),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .wb_data(wb_data),
      .wb_dest(wb_dest), .wb_regwrite(wb_regwrite), .wb_valid(wb_valid), .misalign(misalign)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---- reference model: access size in bytes, 0 for non-memory ops ----
   function automatic int nbytes_of(input logic [5:0] op);
      case (op)
         6'h20, 6'h24, 6'h28: return 1;
         6'h21, 6'h25, 6'h29: return 2;
         6'h23, 6'h2B:        return 4;
         default:             return 0;
      endcase
   endfunction

   function automatic bit is_store_op(input logic [5:0] op);
      return (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
   endfunction

   function automatic bit misaligned_ref(input int n, input int a);
      return ALIGN_CHK && (((n == 2) && (a % 2 != 0)) || ((n == 4) && (a != 0)));
   endfunction

   function automatic logic [3:0] ref_be(input int n, input int a);
      if (n == 1) return 4'(1 << a);
      else if (n == 2) return 4'(3 << (2 * (a / 2)));
      else return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input int n, input logic [31:0] v);
      if (n == 1) return {24'd0, v[7:0]} * 32'h0101_0101;
      else if (n == 2) return {16'd0, v[15:0]} * 32'h0001_0001;
      else return v;
   endfunction

   function automatic logic [31:0] ref_load(input logic [5:0] op, input int a, input logic [31:0] rdata);
      int          n;
      int          sh;
      logic [31:0] mask;
      logic [31:0] v;
      n = nbytes_of(op);
      if (n == 4) return rdata;
      sh   = (n == 1) ? 8 * a : 16 * (a / 2);
      mask = (32'd1 << (8 * n)) - 32'd1;
      v    = (rdata >> sh) & mask;
      if (((op == 6'h20) || (op == 6'h21)) && v[8 * n - 1]) v = v | ~mask;
      return v;
   endfunction

   // Presents one instruction right after a clock edge and follows it to retirement.
   task automatic run_op(input logic [5:0] op, input logic [31:0] alu, input logic [31:0] valb,
                         input logic [4:0] dest, input logic [7:0] sig, input int delay,
                         input logic [31:0] rdata);
      int n;
      int a;
      bit st;
      bit mis;
      int hold_cycles;
      n   = nbytes_of(op);
      a   = int'(alu[1:0]);
      st  = is_store_op(op);
      mis = (n != 0) && misaligned_ref(n, a);
      op_in = op; alu_in = alu; valB_in = valb; dest_in = dest; signals_in = sig;
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clock);
      check("req_idle", 32'(mem_req), 32'd0);
      if ((n == 0) || mis) begin
         check("hold_nonmem", 32'(hold), 32'd0);
         @(posedge clock); #1;
         check("wb_valid_nonmem", 32'(wb_valid), 32'd1);
         check("wb_dest_nonmem", 32'(wb_dest), 32'(dest));
         check("misalign", 32'(misalign), 32'(mis));
         check("req_after_nonmem", 32'(mem_req), 32'd0);
         if (mis) begin
            check("wb_regwrite_mis", 32'(wb_regwrite), 32'd0);
         end else begin
            check("wb_data_alu", wb_data, alu);
            check("wb_regwrite_nonmem", 32'(wb_regwrite), 32'(sig[2]));
         end
      end else begin
         hold_cycles = hold ? 1 : 0;
         for (int k = 0; k <= delay; k++) begin
            @(posedge clock); #1;
            mem_ready = (k == delay);
            mem_rdata = (k == delay) ? rdata : $urandom;
            @(negedge clock);
            if (hold) hold_cycles++;
            check("mem_req", 32'(mem_req), 32'd1);
            check("mem_addr", mem_addr, {alu[31:2], 2'b00});
            check("mem_be", 32'(mem_be), 32'(ref_be(n, a)));
            check("mem_we", 32'(mem_we), 32'(st));
            if (st) check("mem_wdata", mem_wdata, ref_wdata(n, valb));
            check("wb_valid_req", 32'(wb_valid), 32'd0);
         end
         @(posedge clock); #1;
         mem_ready = 1'($urandom);
         mem_rdata = $urandom;
         @(negedge clock);
         if (hold) hold_cycles++;
         check("req_done", 32'(mem_req), 32'd0);
         check("hold_cycles", 32'(hold_cycles), 32'(delay + 2));
         @(posedge clock); #1;
         check("wb_valid_mem", 32'(wb_valid), 32'd1);
         check("wb_dest_mem", 32'(wb_dest), 32'(dest));
         check("wb_data_mem", wb_data, st ? 32'd0 : ref_load(op, a, rdata));
         check("wb_regwrite_mem", 32'(wb_regwrite), st ? 32'd0 : 32'(sig[2]));
         check("misalign_mem", 32'(misalign), 32'd0);
      end
   endtask

   logic [5:0] op_tab [11];

   initial begin
      op_tab = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h09, 6'h0F};

      // reset state
      reset = 1'b1; op_in = 6'h00; alu_in = 32'h0; valB_in = 32'h0; dest_in = 5'd0;
      signals_in = 8'h00; mem_ready = 1'b0; mem_rdata = 32'h0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_hold", 32'(hold), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_wb_dest", 32'(wb_dest), 32'd0);
      check("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_misalign", 32'(misalign), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;

      // plan steps
      run_op(6'h00, 32'h0000_1234, 32'h0, 5'd5, 8'h04, 0, 32'h0);
      run_op(6'h20, 32'h0000_0103, 32'h0, 5'd7, 8'h04, 0, 32'h80FF_0000);
      run_op(6'h29, 32'h0000_0202, 32'hABCD_1234, 5'd9, 8'h04, 4, 32'h0);
      run_op(6'h25, 32'h0000_0000, 32'h0, 5'd3, 8'h04, 1, 32'h0000_F00D);
      run_op(6'h23, 32'h0000_0040, 32'h0, 5'd4, 8'h04, 2, 32'hDEAD_BEEF);
      run_op(6'h23, 32'h0000_0006, 32'h0, 5'd6, 8'h04, 0, 32'h1357_9BDF);

      // reset abandons an access in REQ
      op_in = 6'h23; alu_in = 32'h0000_0080; dest_in = 5'd8; signals_in = 8'h04; mem_ready = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      check("abort_req_before", 32'(mem_req), 32'd1);
      @(posedge clock); #1;
      reset = 1'b1; op_in = 6'h00;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      check("abort_mem_req", 32'(mem_req), 32'd0);
      check("abort_hold", 32'(hold), 32'd0);
      check("abort_wb_valid", 32'(wb_valid), 32'd0);
      @(posedge clock); #1;
      run_op(6'h24, 32'h0000_0011, 32'h0, 5'd2, 8'h04, 0, 32'h0000_9A00);

      // randomized ops
      for (int i = 0; i < 40; i++) begin
         run_op(op_tab[$urandom_range(0, 10)], $urandom, $urandom, 5'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
